term_tile_cfg_frame_ctrl: RTL and testbench

- Next-generation configuration front end for fabric termination tiles such as N/S/E/W single terms.
- Replaces the fixed 20-strobe pass-through and the implicit CONFin/CONFout chaining with a parametrised frame store that has two load paths: a parallel FrameData/FrameStrobe path and a serial daisy chain.
- Configuration is written into shadow bits. The shadow is committed atomically to the active ConfigBits that drive the tile switch matrix when MODE leaves configuration.

---
 rtl/term_cfg_pkg.sv | 18 +
 rtl/term_tile_cfg_frame_ctrl_if.sv | 39 +++
 rtl/term_cfg_serial_shifter.sv | 67 ++++++
 rtl/term_tile_cfg_frame_ctrl.sv | 157 +++++++++++++++
 tb/tb_term_tile_cfg_frame_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/term_cfg_pkg.sv
// Shared definitions for the termination-tile configuration frame controller.
// Contents:
//   cfg_state_e - controller state (IDLE, CONFIG, COMMIT)
//   idx_width   - width of an index able to address n entries (never below 1)
package term_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

    // Width needed to hold 0..n-1; a single-entry space still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/term_tile_cfg_frame_ctrl_if.sv
// Frame/serial configuration bus of a termination tile.
// Signals:
//   FrameData     - parallel frame word (master -> slave)
//   FrameStrobe   - one-hot row write strobe (master -> slave)
//   FrameData_O   - pass-through of FrameData (slave -> master)
//   FrameStrobe_O - pass-through of FrameStrobe (slave -> master)
//   CONFin        - serial configuration data (master -> slave)
//   CONFout       - serial chain output (slave -> master)
interface term_tile_cfg_frame_ctrl_if #(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32
);

    logic [FrameBitsPerRow-1:0] FrameData;
    logic [MaxFramesPerCol-1:0] FrameStrobe;
    logic [FrameBitsPerRow-1:0] FrameData_O;
    logic [MaxFramesPerCol-1:0] FrameStrobe_O;
    logic                       CONFin;
    logic                       CONFout;

    modport master (
        output FrameData,
        output FrameStrobe,
        output CONFin,
        input  FrameData_O,
        input  FrameStrobe_O,
        input  CONFout
    );

    modport slave (
        input  FrameData,
        input  FrameStrobe,
        input  CONFin,
        output FrameData_O,
        output FrameStrobe_O,
        output CONFout
    );

endinterface

// File: rtl/term_cfg_serial_shifter.sv
// Serial daisy-chain shifter for the configuration frame controller.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   shift_en   - shift serial_in in and advance the bit counter this cycle
//   clear      - clear the bit counter (partial word discarded); shift data holds
//   serial_in  - serial data in
//   serial_out - MSB of the shift register
//   word       - current shift register contents
//   word_done  - one-cycle pulse after the edge that completed a word; word is
//                the finished word during this pulse
module term_cfg_serial_shifter
    import term_cfg_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [Width-1:0] word,
    output logic             word_done
);

    localparam int unsigned     CntW   = idx_width(Width);
    localparam logic [CntW-1:0] CntMax = CntW'(Width - 1);

    logic [Width-1:0] shift_q, shift_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             word_done_q, word_done_d;

    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        word_done_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (shift_en) begin
            shift_d    = shift_q << 1;
            shift_d[0] = serial_in;
            if (cnt_q == CntMax) begin
                cnt_d       = '0;
                word_done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            word_done_q <= word_done_d;
        end
    end

    assign serial_out = shift_q[Width-1];
    assign word       = shift_q;
    assign word_done  = word_done_q;

endmodule

// File: rtl/term_tile_cfg_frame_ctrl.sv
// Configuration front end for fabric termination tiles.
// Configuration is loaded into a shadow store through either the parallel
// frame path or the serial daisy chain, and committed atomically to ConfigBits
// in the single COMMIT cycle that follows MODE leaving configuration.
// Ports:
//   CLK, resetn - tile clock, asynchronous active-low reset
//   MODE        - 1 = configuration, 0 = operation
//   cfg_bus     - frame data/strobe inputs and pass-throughs, CONFin/CONFout
//   ConfigBits  - active configuration driving the switch matrix
//   frame_ptr   - destination row of the next completed serial word
//   cfg_done    - sticky: frame_ptr wrapped, every row loaded serially once
//   cfg_err     - sticky: multi-hot FrameStrobe seen during configuration
// NoConfigBits must lie in 1..MaxFramesPerCol*FrameBitsPerRow.
module term_tile_cfg_frame_ctrl
    import term_cfg_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned NoConfigBits    = 64
) (
    input  logic                                 CLK,
    input  logic                                 resetn,
    input  logic                                 MODE,
    term_tile_cfg_frame_ctrl_if.slave            cfg_bus,
    output logic [NoConfigBits-1:0]              ConfigBits,
    output logic [idx_width(MaxFramesPerCol)-1:0] frame_ptr,
    output logic                                 cfg_done,
    output logic                                 cfg_err
);

    localparam int unsigned     PtrW   = idx_width(MaxFramesPerCol);
    localparam logic [PtrW-1:0] PtrMax = PtrW'(MaxFramesPerCol - 1);

    cfg_state_e                 state_q, state_d;
    logic [NoConfigBits-1:0]    shadow_q, shadow_d;
    logic [NoConfigBits-1:0]    config_bits_q, config_bits_d;
    logic [PtrW-1:0]            frame_ptr_q, frame_ptr_d;
    logic                       cfg_done_q, cfg_done_d;
    logic                       cfg_err_q, cfg_err_d;

    logic                       in_cfg;
    logic                       enter_cfg;
    logic                       leave_cfg;
    logic                       shift_en;
    logic                       cnt_clear;
    logic                       strobe_onehot;
    logic                       strobe_multi;
    logic                       par_we;
    logic                       ser_we;
    logic [FrameBitsPerRow-1:0] ser_word;
    logic                       ser_word_done;
    logic                       conf_out;

    // Pass-throughs stay live in every state.
    assign cfg_bus.FrameData_O   = cfg_bus.FrameData;
    assign cfg_bus.FrameStrobe_O = cfg_bus.FrameStrobe;
    assign cfg_bus.CONFout       = conf_out;

    assign in_cfg    = (state_q == CONFIG);
    // From IDLE or COMMIT, MODE=1 enters CONFIG at this edge.
    assign enter_cfg = !in_cfg && MODE;
    assign leave_cfg = in_cfg && !MODE;
    // No shift on the MODE-fall edge so CONFout holds its last value.
    assign shift_en  = in_cfg && MODE;
    assign cnt_clear = enter_cfg || leave_cfg;

    assign strobe_onehot = $onehot(cfg_bus.FrameStrobe);
    assign strobe_multi  = !$onehot0(cfg_bus.FrameStrobe);
    assign par_we        = in_cfg && strobe_onehot;
    // A word completed on the final CONFIG edge is still stored.
    assign ser_we        = in_cfg && ser_word_done;

    term_cfg_serial_shifter #(
        .Width(FrameBitsPerRow)
    ) u_shifter (
        .clk       (CLK),
        .rst_n     (resetn),
        .shift_en  (shift_en),
        .clear     (cnt_clear),
        .serial_in (cfg_bus.CONFin),
        .serial_out(conf_out),
        .word      (ser_word),
        .word_done (ser_word_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (MODE) state_d = CONFIG;
            CONFIG:  if (!MODE) state_d = COMMIT;
            COMMIT:  state_d = MODE ? CONFIG : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_ptr_d = frame_ptr_q;
        cfg_done_d  = cfg_done_q;
        cfg_err_d   = cfg_err_q;
        if (enter_cfg) begin
            frame_ptr_d = '0;
            cfg_done_d  = 1'b0;
            cfg_err_d   = 1'b0;
        end else if (in_cfg) begin
            if (strobe_multi) begin
                cfg_err_d = 1'b1;
            end
            if (ser_we) begin
                if (frame_ptr_q == PtrMax) begin
                    frame_ptr_d = '0;
                    cfg_done_d  = 1'b1;
                end else begin
                    frame_ptr_d = frame_ptr_q + PtrW'(1);
                end
            end
        end
    end

    // Bit i belongs to row i/FrameBitsPerRow, column i%FrameBitsPerRow; rows
    // past NoConfigBits simply have no storage. Parallel wins a same-row clash.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NoConfigBits; i++) begin
            if (par_we && cfg_bus.FrameStrobe[i / FrameBitsPerRow]) begin
                shadow_d[i] = cfg_bus.FrameData[i % FrameBitsPerRow];
            end else if (ser_we && (int'(frame_ptr_q) == i / FrameBitsPerRow)) begin
                shadow_d[i] = ser_word[i % FrameBitsPerRow];
            end
        end
    end

    assign config_bits_d = (state_q == COMMIT) ? shadow_q : config_bits_q;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            config_bits_q <= '0;
            frame_ptr_q   <= '0;
            cfg_done_q    <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            config_bits_q <= config_bits_d;
            frame_ptr_q   <= frame_ptr_d;
            cfg_done_q    <= cfg_done_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign ConfigBits = config_bits_q;
    assign frame_ptr  = frame_ptr_q;
    assign cfg_done   = cfg_done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_term_tile_cfg_frame_ctrl.sv
// Directed self-checking bench for term_tile_cfg_frame_ctrl (default parameters).
module tb_term_tile_cfg_frame_ctrl;

    logic        CLK;
    logic        resetn;
    logic        MODE;
    logic [63:0] ConfigBits;
    logic [4:0]  frame_ptr;
    logic        cfg_done;
    logic        cfg_err;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] cap;

    term_tile_cfg_frame_ctrl_if #(
        .MaxFramesPerCol(20),
        .FrameBitsPerRow(32)
    ) bus ();

    term_tile_cfg_frame_ctrl #(
        .MaxFramesPerCol(20),
        .FrameBitsPerRow(32),
        .NoConfigBits   (64)
    ) dut (
        .CLK       (CLK),
        .resetn    (resetn),
        .MODE      (MODE),
        .cfg_bus   (bus),
        .ConfigBits(ConfigBits),
        .frame_ptr (frame_ptr),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Shift w MSB-first; cap[k] is CONFout seen just before bit k goes in.
    task automatic shift_word(input logic [31:0] w, output logic [31:0] c);
        for (int k = 31; k >= 0; k--) begin
            c[k]       = bus.CONFout;
            bus.CONFin = w[k];
            tick();
        end
    endtask

    task automatic commit_and_check(input string tag, input logic [63:0] old_v,
                                    input logic [63:0] new_v);
        MODE = 1'b0;
        tick();
        check({tag, "_hold"}, ConfigBits, old_v);
        tick();
        check({tag, "_commit"}, ConfigBits, new_v);
    endtask

    initial begin
        logic [31:0] w;
        resetn          = 1'b0;
        MODE            = 1'b0;
        bus.FrameData   = '0;
        bus.FrameStrobe = '0;
        bus.CONFin      = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Reset state and pass-throughs
        check("rst_cfgbits", ConfigBits, 64'h0);
        check("rst_ptr", frame_ptr, 64'h0);
        check("rst_done", cfg_done, 64'h0);
        check("rst_err", cfg_err, 64'h0);
        check("rst_confout", bus.CONFout, 64'h0);
        bus.FrameData   = 32'hDEADBEEF;
        bus.FrameStrobe = 20'h80001;
        #1;
        check("pt_data", bus.FrameData_O, 64'hDEADBEEF);
        check("pt_strobe", bus.FrameStrobe_O, 64'h80001);
        bus.FrameStrobe = '0;

        // Parallel load of rows 0 and 1
        MODE = 1'b1;
        tick();
        bus.FrameData   = 32'hDEADBEEF;
        bus.FrameStrobe = 20'h00001;
        tick();
        bus.FrameData   = 32'h12345678;
        bus.FrameStrobe = 20'h00002;
        tick();
        bus.FrameStrobe = '0;
        commit_and_check("par", 64'h0, 64'h12345678_DEADBEEF);

        // Multi-hot strobe: no write, sticky error, cleared on next entry
        MODE = 1'b1;
        tick();
        bus.FrameData   = 32'hFFFFFFFF;
        bus.FrameStrobe = 20'h00003;
        tick();
        bus.FrameStrobe = '0;
        check("err_set", cfg_err, 64'h1);
        commit_and_check("err", 64'h12345678_DEADBEEF, 64'h12345678_DEADBEEF);
        check("err_sticky", cfg_err, 64'h1);
        MODE = 1'b1;
        tick();
        check("err_clr", cfg_err, 64'h0);

        // Serial load of rows 0 and 1, CONFout echo
        shift_word(32'hA5A5A5A5, cap);
        check("ser_cap0", cap, 64'h0);
        check("ser_ptr_pend", frame_ptr, 64'h0);
        shift_word(32'h6B1E94D2, cap);
        check("ser_ptr1", frame_ptr, 64'h1);
        check("ser_echo", cap, 64'hA5A5A5A5);
        bus.CONFin = 1'b0;
        tick();
        check("ser_ptr2", frame_ptr, 64'h2);
        commit_and_check("ser", 64'h12345678_DEADBEEF, 64'h6B1E94D2_A5A5A5A5);
        check("confout_hold", bus.CONFout, 64'h1);

        // Full serial load of 20 rows; rows 2..19 have no storage
        MODE = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            w = 32'h01010101 * (i + 1);
            shift_word(w, cap);
        end
        check("full_ptr19", frame_ptr, 64'd19);
        check("full_done0", cfg_done, 64'h0);
        bus.CONFin = 1'b0;
        tick();
        check("full_ptr_wrap", frame_ptr, 64'h0);
        check("full_done1", cfg_done, 64'h1);
        commit_and_check("full", 64'h6B1E94D2_A5A5A5A5, 64'h02020202_01010101);
        check("full_done_sticky", cfg_done, 64'h1);

        // Same-row collision: parallel wins, frame_ptr still advances
        MODE = 1'b1;
        tick();
        check("col_done_clr", cfg_done, 64'h0);
        shift_word(32'hFFFF0000, cap);
        bus.FrameData   = 32'h0000FFFF;
        bus.FrameStrobe = 20'h00001;
        bus.CONFin      = 1'b0;
        tick();
        bus.FrameStrobe = '0;
        check("col_ptr", frame_ptr, 64'h1);
        commit_and_check("col", 64'h02020202_01010101, 64'h02020202_0000FFFF);

        // Different rows in the same cycle: both written
        MODE = 1'b1;
        tick();
        shift_word(32'hCAFEF00D, cap);
        bus.FrameData   = 32'h12121212;
        bus.FrameStrobe = 20'h00002;
        bus.CONFin      = 1'b0;
        tick();
        bus.FrameStrobe = '0;
        commit_and_check("both", 64'h02020202_0000FFFF, 64'h12121212_CAFEF00D);

        // All-ones config, then asynchronous reset mid-word
        MODE = 1'b1;
        tick();
        bus.FrameData   = 32'hFFFFFFFF;
        bus.FrameStrobe = 20'h00001;
        tick();
        bus.FrameStrobe = 20'h00002;
        tick();
        bus.FrameStrobe = '0;
        commit_and_check("ones", 64'h12121212_CAFEF00D, 64'hFFFFFFFF_FFFFFFFF);
        MODE = 1'b1;
        tick();
        bus.CONFin = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("pre_rst_confout", bus.CONFout, 64'h1);
        check("pre_rst_ptr", frame_ptr, 64'h1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_cfgbits", ConfigBits, 64'h0);
        check("arst_ptr", frame_ptr, 64'h0);
        check("arst_confout", bus.CONFout, 64'h0);
        MODE       = 1'b0;
        bus.CONFin = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        // Strobe outside CONFIG is ignored; shadow was cleared by reset
        bus.FrameData   = 32'h5A5A5A5A;
        bus.FrameStrobe = 20'h00001;
        tick();
        bus.FrameStrobe = '0;
        MODE = 1'b1;
        tick();
        commit_and_check("post_rst", 64'h0, 64'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
